ex_mux_pipe: RTL

Parametrised N-input, WIDTH-bit operand selector for the EX stage, with a registered output and a valid/ready handshake. Each accepted beat carries a select code and an input vector, and produces one output word. A 2-entry skid buffer gives full throughput while keeping in_ready registered. It replaces the purely combinational 5:1 32-bit EX selector between the forwarding logic and the ALU.

---
 rtl/ex_mux_pkg.sv | 25 ++
 rtl/ex_mux_sel.sv | 27 ++
 rtl/ex_mux_pipe.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ex_mux_pkg.sv
// rtl/ex_mux_pkg.sv - shared constants, state encoding and select-width helper for ex_mux_pipe
package ex_mux_pkg;

  localparam int EX_WIDTH_DEF  = 32;
  localparam int EX_NUM_IN_DEF = 5;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_ONE   = ST_ONE,
    S_TWO   = ST_TWO
  } state_t;

  // Smallest select width able to address n inputs (never below 1).
  function automatic int ex_min_sel_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/ex_mux_sel.sv
// rtl/ex_mux_sel.sv - combinational slice selector with select range check
module ex_mux_sel
  import ex_mux_pkg::*;
#(
  parameter int WIDTH  = EX_WIDTH_DEF,
  parameter int NUM_IN = EX_NUM_IN_DEF,
  parameter int SEL_W  = 3
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        word,
  output logic                    sel_err
);

  // Out-of-range codes fall through with word=0 and the error flag set.
  always_comb begin
    word    = '0;
    sel_err = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        word    = in_data[k*WIDTH +: WIDTH];
        sel_err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ex_mux_pipe.sv
// rtl/ex_mux_pipe.sv - registered EX operand selector with 2-entry skid buffer and valid/ready
// Optional out_par port enabled by EX_MUX_PIPE_PARITY_EN.
module ex_mux_pipe
  import ex_mux_pkg::*;
#(
  parameter int WIDTH  = EX_WIDTH_DEF,
  parameter int NUM_IN = EX_NUM_IN_DEF,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef EX_MUX_PIPE_PARITY_EN
  output logic                    out_par,
`endif
  output logic                    sel_err
);

  generate
    if (NUM_IN < 2 || NUM_IN > 16 || SEL_W < ex_min_sel_w(NUM_IN)) begin : g_bad_param
      $error("ex_mux_pipe: NUM_IN must be 2..16 and 2**SEL_W >= NUM_IN");
    end
  endgenerate

  state_t           state_q, state_d;
  logic             in_ready_q;
  logic [WIDTH-1:0] m_data_q, s_data_q;
  logic             m_err_q, s_err_q;
  logic [WIDTH-1:0] sel_word;
  logic             sel_err_c;
  logic             accept, out_xfer;
  logic             load_m, load_s, move_s;

  ex_mux_sel #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_sel (
    .in_data (in_data),
    .sel     (sel),
    .word    (sel_word),
    .sel_err (sel_err_c)
  );

  assign accept    = in_valid & in_ready_q;
  assign out_valid = (state_q != S_EMPTY);
  assign out_xfer  = out_valid & out_ready;
  assign in_ready  = in_ready_q;
  assign out_data  = m_data_q;
  assign sel_err   = m_err_q;

  always_comb begin
    state_d = state_q;
    load_m  = 1'b0;
    load_s  = 1'b0;
    move_s  = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d = S_ONE;
          load_m  = 1'b1;
        end
      end
      S_ONE: begin
        if (accept && out_xfer) begin
          load_m = 1'b1;
        end else if (accept) begin
          state_d = S_TWO;
          load_s  = 1'b1;
        end else if (out_xfer) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (out_xfer) begin
          state_d = S_ONE;
          move_s  = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // in_ready is registered from the next state so it never depends on out_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
      m_data_q   <= '0;
      m_err_q    <= 1'b0;
      s_data_q   <= '0;
      s_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != S_TWO);
      if (load_m) begin
        m_data_q <= sel_word;
        m_err_q  <= sel_err_c;
      end else if (move_s) begin
        m_data_q <= s_data_q;
        m_err_q  <= s_err_q;
      end
      if (load_s) begin
        s_data_q <= sel_word;
        s_err_q  <= sel_err_c;
      end else if (move_s) begin
        s_data_q <= '0;
        s_err_q  <= 1'b0;
      end
    end
  end

`ifdef EX_MUX_PIPE_PARITY_EN
  logic m_par_q, s_par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_par_q <= 1'b0;
      s_par_q <= 1'b0;
    end else begin
      if (load_m)      m_par_q <= ^sel_word;
      else if (move_s) m_par_q <= s_par_q;
      if (load_s)      s_par_q <= ^sel_word;
      else if (move_s) s_par_q <= 1'b0;
    end
  end

  assign out_par = m_par_q;
`endif

endmodule
